// File: rtl/wb_trace_fifo.sv
// Write-back trace FIFO: records retired register writes and drains them over valid/ready.
// Define TRACE_TIMESTAMP_EN to tag each record with a free-running cycle count (trace_ts).
module wb_trace_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [31:0]       debug_wb_pc,
   input  logic [3:0]        debug_wb_rf_we,
   input  logic [4:0]        debug_wb_rf_wnum,
   input  logic [31:0]       debug_wb_rf_wdata,
   input  logic              clear,
   output logic              trace_valid,
   input  logic              trace_ready,
   output logic [31:0]       trace_pc,
   output logic [4:0]        trace_wnum,
   output logic [31:0]       trace_wdata,
   output logic [ADDR_W:0]   trace_count,
   output logic              trace_overflow,
`ifdef TRACE_TIMESTAMP_EN
   output logic [31:0]       trace_ts,
`endif
   output logic [15:0]       trace_drop_cnt
);

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  wnum;
      logic [31:0] wdata;
`ifdef TRACE_TIMESTAMP_EN
      logic [31:0] ts;
`endif
   } rec_t;

   rec_t              mem_q [DEPTH];
   rec_t              rec_in;
   rec_t              head;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              overflow_q, overflow_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;
   logic              capture, full, pop, push, drop;

`ifdef TRACE_TIMESTAMP_EN
   logic [31:0] ts_q, ts_d;

   assign ts_d     = ts_q + 32'd1;
   assign trace_ts = head.ts;

   always_ff @(posedge clk) begin
      if (!resetn) ts_q <= '0;
      else         ts_q <= ts_d;
   end
`endif

   always_comb begin
      rec_in       = '0;
      rec_in.pc    = debug_wb_pc;
      rec_in.wnum  = debug_wb_rf_wnum;
      rec_in.wdata = debug_wb_rf_wdata;
`ifdef TRACE_TIMESTAMP_EN
      rec_in.ts    = ts_q;
`endif
   end

   assign head        = mem_q[rd_ptr_q];
   assign trace_valid = (count_q != '0);
   assign trace_pc    = head.pc;
   assign trace_wnum  = head.wnum;
   assign trace_wdata = head.wdata;
   assign trace_count    = count_q;
   assign trace_overflow = overflow_q;
   assign trace_drop_cnt = drop_cnt_q;

   always_comb begin
      capture = (debug_wb_rf_we != 4'b0) && (debug_wb_rf_wnum != 5'd0);
      full    = (count_q == (ADDR_W+1)'(DEPTH));
      pop     = trace_valid && trace_ready;
      // clear swallows the concurrent capture entirely: no write, no drop count
      push    = !clear && capture && (!full || pop);
      drop    = !clear && capture && full && !pop;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;

      if (clear) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         if (push && !pop)      count_d = count_q + (ADDR_W+1)'(1);
         else if (pop && !push) count_d = count_q - (ADDR_W+1)'(1);
         if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // storage is zeroed on reset so the head fields read 0 afterwards
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= rec_in;
      end
   end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Bench for wb_trace_fifo: directed scenarios then random traffic against a queue-based model.
module tb_wb_trace_fifo;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] pc_i;
   logic [3:0]  we_i;
   logic [4:0]  wnum_i;
   logic [31:0] wdata_i;
   logic        clear;
   logic        ready;
   logic        trace_valid;
   logic [31:0] trace_pc;
   logic [4:0]  trace_wnum;
   logic [31:0] trace_wdata;
   logic [4:0]  trace_count;
   logic        trace_overflow;
   logic [15:0] trace_drop_cnt;
`ifdef TRACE_TIMESTAMP_EN
   logic [31:0] trace_ts;
`endif

   always #5 clk = ~clk;

   wb_trace_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .debug_wb_pc       (pc_i),
      .debug_wb_rf_we    (we_i),
      .debug_wb_rf_wnum  (wnum_i),
      .debug_wb_rf_wdata (wdata_i),
      .clear             (clear),
      .trace_valid       (trace_valid),
      .trace_ready       (ready),
      .trace_pc          (trace_pc),
      .trace_wnum        (trace_wnum),
      .trace_wdata       (trace_wdata),
      .trace_count       (trace_count),
      .trace_overflow    (trace_overflow),
`ifdef TRACE_TIMESTAMP_EN
      .trace_ts          (trace_ts),
`endif
      .trace_drop_cnt    (trace_drop_cnt)
   );

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  wnum;
      logic [31:0] wdata;
      logic [31:0] ts;
   } rec_t;

   rec_t        q[$];
   bit          m_ovf;
   int unsigned m_drop;
   logic [31:0] m_cycle;
   bit          m_fresh;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic drive(input logic [3:0] we, input logic [4:0] n, input logic [31:0] d,
                        input logic [31:0] pc, input logic rdy, input logic clr);
      we_i = we; wnum_i = n; wdata_i = d; pc_i = pc; ready = rdy; clear = clr;
   endtask

   // advance one clock, update the model from the inputs seen at that edge, compare
   task automatic step(input string tag);
      bit   cap, full, pop;
      rec_t r;
      cap  = (we_i != 4'b0) && (wnum_i != 5'd0);
      full = (q.size() == 16);
      pop  = (q.size() != 0) && ready;
      r.pc = pc_i; r.wnum = wnum_i; r.wdata = wdata_i; r.ts = m_cycle;
      @(posedge clk);
      if (!resetn) begin
         q.delete(); m_ovf = 0; m_drop = 0; m_cycle = 0; m_fresh = 1;
      end else begin
         m_cycle = m_cycle + 32'd1;
         if (clear) begin
            q.delete(); m_ovf = 0; m_drop = 0;
         end else begin
            if (pop) begin
               void'(q.pop_front());
               m_fresh = 0;
            end
            if (cap) begin
               if (full && !pop) begin
                  m_ovf = 1;
                  if (m_drop < 32'hFFFF) m_drop++;
               end else begin
                  q.push_back(r);
                  m_fresh = 0;
               end
            end
         end
      end
      #1;
      check({tag, ".count"}, 32'(trace_count), 32'(q.size()));
      check({tag, ".valid"}, 32'(trace_valid), 32'(q.size() != 0));
      check({tag, ".ovf"},   32'(trace_overflow), 32'(m_ovf));
      check({tag, ".drop"},  32'(trace_drop_cnt), m_drop);
      if (q.size() != 0) begin
         check({tag, ".pc"},    trace_pc, q[0].pc);
         check({tag, ".wnum"},  32'(trace_wnum), 32'(q[0].wnum));
         check({tag, ".wdata"}, trace_wdata, q[0].wdata);
`ifdef TRACE_TIMESTAMP_EN
         check({tag, ".ts"},    trace_ts, q[0].ts);
`endif
      end else if (m_fresh) begin
         check({tag, ".pc0"},    trace_pc, 32'h0);
         check({tag, ".wdata0"}, trace_wdata, 32'h0);
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      drive(4'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      step("rst");
      step("rst");
      resetn = 1'b1;
   endtask

   initial begin
      m_cycle = 0; m_fresh = 1; m_ovf = 0; m_drop = 0;
      do_reset();
      check("reset_count", 32'(trace_count), 32'd0);
      check("reset_wnum",  32'(trace_wnum), 32'd0);

      // single record, held then popped
      drive(4'hF, 5'd5, 32'h1234, 32'h1C000000, 1'b0, 1'b0);
      step("t1_cap");
      check("t1_valid", 32'(trace_valid), 32'd1);
      check("t1_wdata", trace_wdata, 32'h1234);
      check("t1_pc",    trace_pc, 32'h1C000000);
      drive(4'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      step("t1_hold");
      check("t1_hold_wnum", 32'(trace_wnum), 32'd5);
      ready = 1'b1;
      step("t1_pop");
      check("t1_empty", 32'(trace_valid), 32'd0);

      // writes to r0 and writes with no byte enables are not captured
      drive(4'hF, 5'd0, 32'hAAAA, 32'h100, 1'b1, 1'b0);
      step("t2_r0");
      drive(4'h0, 5'd3, 32'hBBBB, 32'h104, 1'b1, 1'b0);
      step("t2_we0");
      check("t2_count", 32'(trace_count), 32'd0);
      check("t2_ovf",   32'(trace_overflow), 32'd0);

      // 20 captures into a 16-deep FIFO with the sink stalled
      for (int i = 0; i < 20; i++) begin
         drive(4'h1 << (i % 4), 5'(1 + i % 31), 32'hC000 + 32'(i), 32'h2000 + 32'(4 * i), 1'b0, 1'b0);
         step("t3_fill");
      end
      check("t3_count", 32'(trace_count), 32'd16);
      check("t3_ovf",   32'(trace_overflow), 32'd1);
      check("t3_drop",  32'(trace_drop_cnt), 32'd4);
      check("t3_first", trace_wdata, 32'hC000);
      drive(4'h0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) check("t3_last", trace_wdata, 32'hC00F);
         step("t3_drain");
      end

      // full FIFO accepts a capture when the sink pops in the same cycle
      drive(4'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
      step("t4_clr");
      for (int i = 0; i < 16; i++) begin
         drive(4'hF, 5'd7, 32'hD000 + 32'(i), 32'h3000, 1'b0, 1'b0);
         step("t4_fill");
      end
      drive(4'hF, 5'd9, 32'hDEAD, 32'h3FFC, 1'b1, 1'b0);
      step("t4_both");
      check("t4_count", 32'(trace_count), 32'd16);
      check("t4_drop",  32'(trace_drop_cnt), 32'd0);
      drive(4'h0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) check("t4_last", trace_wdata, 32'hDEAD);
         step("t4_drain");
      end

      // clear with a concurrent capture
      for (int i = 0; i < 3; i++) begin
         drive(4'hF, 5'd4, 32'hE000 + 32'(i), 32'h4000, 1'b0, 1'b0);
         step("t5_fill");
      end
      drive(4'hF, 5'd4, 32'hE0FF, 32'h4000, 1'b0, 1'b1);
      step("t5_clr");
      check("t5_count", 32'(trace_count), 32'd0);
      check("t5_valid", 32'(trace_valid), 32'd0);
      check("t5_drop",  32'(trace_drop_cnt), 32'd0);
      drive(4'h3, 5'd6, 32'hF00D, 32'h5000, 1'b0, 1'b0);
      step("t5_next");
      check("t5_head", trace_wdata, 32'hF00D);

`ifdef TRACE_TIMESTAMP_EN
      do_reset();
      drive(4'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step("t6_idle");
      drive(4'hF, 5'd1, 32'h10, 32'h0, 1'b0, 1'b0);
      step("t6_cap10");
      drive(4'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      step("t6_idle");
      step("t6_idle");
      drive(4'hF, 5'd1, 32'h13, 32'h0, 1'b0, 1'b0);
      step("t6_cap13");
      check("t6_ts10", trace_ts, 32'd10);
      drive(4'h0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);
      step("t6_pop");
      check("t6_ts13", trace_ts, 32'd13);
      step("t6_pop");
`endif

      // random traffic, including occasional clear and mid-stream reset
      for (int i = 0; i < 3000; i++) begin
         resetn = ($urandom_range(0, 299) != 0);
         drive(($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom),
               ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
               $urandom, $urandom,
               ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 30 : 80)),
               ($urandom_range(0, 99) == 0));
         step("rand");
      end
      resetn = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
